// File: rtl/usb_tx_burst_scheduler_pkg.sv
// Shared types and constants for the USB3 TX burst scheduler.
// Burst header layout: {tag, completed-burst sequence, burst length}.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CTRL,
    ST_MD_HDR,
    ST_MD_DATA
  } sched_state_e;

  typedef enum logic {
    SRC_CTRL,
    SRC_MD
  } word_src_e;

  localparam logic [7:0] HDR_TAG_DEF = 8'hD0;
  localparam logic [7:0] MD_TAG_DEF  = 8'hDA;

  function automatic logic [39:0] make_header(input logic [7:0]  tag,
                                              input logic [15:0] seq,
                                              input logic [15:0] len);
    return {tag, seq, len};
  endfunction

endpackage

// File: rtl/usb_tx_burst_scheduler_if.sv
// FIFO-side signal bundle of the scheduler: control FIFO, measured-data FIFO, TX FIFO.
// master = scheduler, slave = FIFO environment.
interface usb_tx_burst_scheduler_if #(
  parameter int CNT_W = 12
);
  logic             Control_Fifo_Empty;
  logic [39:0]      Control_Fifo_Data;
  logic             Control_Fifo_RE;
  logic             MD_Fifo_Empty;
  logic [CNT_W-1:0] MD_Fifo_Count;
  logic [31:0]      MD_Fifo_Data;
  logic             MD_Fifo_RE;
  logic             TX_Fifo_AFull;
  logic             TX_Fifo_WE;
  logic [39:0]      TX_Fifo_Data;

  modport master (
    input  Control_Fifo_Empty, Control_Fifo_Data,
    input  MD_Fifo_Empty, MD_Fifo_Count, MD_Fifo_Data,
    input  TX_Fifo_AFull,
    output Control_Fifo_RE, MD_Fifo_RE,
    output TX_Fifo_WE, TX_Fifo_Data
  );

  modport slave (
    output Control_Fifo_Empty, Control_Fifo_Data,
    output MD_Fifo_Empty, MD_Fifo_Count, MD_Fifo_Data,
    output TX_Fifo_AFull,
    input  Control_Fifo_RE, MD_Fifo_RE,
    input  TX_Fifo_WE, TX_Fifo_Data
  );
endinterface

// File: rtl/usb_tx_burst_scheduler_word_packer.sv
// Write pipeline: RE -> source/valid stage -> registered TX word (header, control or tagged MD).
// Headers enter the output register directly, so their WE follows the grant by one cycle.
module usb_tx_word_packer
  import usb_tx_pkg::*;
#(
  parameter logic [7:0] MD_TAG = MD_TAG_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_re,
  input  logic        md_re,
  input  logic        md_last,
  input  logic        hdr_we,
  input  logic [39:0] hdr_word,
  input  logic [39:0] ctrl_q,
  input  logic [31:0] md_q,
  output logic        tx_we,
  output logic [39:0] tx_data,
  output logic        last_wr,
  output logic        busy
);
  logic        vld1_q, vld1_d;
  word_src_e   src1_q, src1_d;
  logic        last1_q, last1_d;
  logic        we_q, we_d;
  logic [39:0] data_q, data_d;

  always_comb begin
    vld1_d  = ctrl_re | md_re;
    src1_d  = md_re ? SRC_MD : SRC_CTRL;
    last1_d = md_re & md_last;
    we_d    = hdr_we | vld1_q;
    data_d  = data_q;
    if (hdr_we) begin
      data_d = hdr_word;
    end else if (vld1_q) begin
      data_d = (src1_q == SRC_MD) ? {MD_TAG, md_q} : ctrl_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1_q  <= 1'b0;
      src1_q  <= SRC_CTRL;
      last1_q <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      vld1_q  <= vld1_d;
      src1_q  <= src1_d;
      last1_q <= last1_d;
      we_q    <= we_d;
      data_q  <= data_d;
    end
  end

  assign tx_we   = we_q;
  assign tx_data = data_q;
  // High in the cycle the last word of a burst is being loaded into the output register.
  assign last_wr = vld1_q & last1_q;
  assign busy    = vld1_q | we_q;
endmodule

// File: rtl/usb_tx_burst_scheduler.sv
// Shares the TX FIFO between control responses and fixed-length tagged measured-data bursts.
// Control has priority; after MAX_CTRL_RUN control words a ready MD burst gets the next grant.
module usb_tx_burst_scheduler
  import usb_tx_pkg::*;
#(
  parameter int          MD_BURST_LEN = 256,
  parameter int          CNT_W        = 12,
  parameter int          MAX_CTRL_RUN = 4,
  parameter logic [7:0]  HDR_TAG      = HDR_TAG_DEF,
  parameter logic [7:0]  MD_TAG       = MD_TAG_DEF
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Enable,
  usb_tx_burst_scheduler_if.master   bus,
  output logic                       Busy,
  output logic [15:0]                Burst_Seq
);
  localparam int RUN_W = $clog2(MAX_CTRL_RUN + 1);

  sched_state_e     state_q, state_d;
  logic [RUN_W-1:0] ctrl_run_q, ctrl_run_d;
  logic             yield_q, yield_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]      seq_q, seq_d;

  logic        md_ready;
  logic        ctrl_re, md_re, md_last, hdr_we;
  logic        last_wr, pipe_busy;
  logic [39:0] hdr_word;

  assign md_ready = (bus.MD_Fifo_Count >= CNT_W'(MD_BURST_LEN));
  assign hdr_word = make_header(HDR_TAG, seq_q, 16'(MD_BURST_LEN));

  always_comb begin
    state_d    = state_q;
    ctrl_run_d = ctrl_run_q;
    yield_d    = yield_q;
    word_cnt_d = word_cnt_q;
    seq_d      = seq_q;
    ctrl_re    = 1'b0;
    md_re      = 1'b0;
    md_last    = 1'b0;
    hdr_we     = 1'b0;
    if (last_wr) seq_d = seq_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (!md_ready) yield_d = 1'b0;
        if (Enable) begin
          if (!bus.Control_Fifo_Empty && !(yield_q && md_ready)) state_d = ST_CTRL;
          else if (md_ready)                                     state_d = ST_MD_HDR;
        end
      end
      ST_CTRL: begin
        ctrl_re = Enable && !bus.Control_Fifo_Empty && !bus.TX_Fifo_AFull;
        if (!Enable || bus.Control_Fifo_Empty) begin
          state_d    = ST_IDLE;
          ctrl_run_d = '0;
        end else if (ctrl_re) begin
          if (ctrl_run_q == RUN_W'(MAX_CTRL_RUN - 1)) begin
            state_d    = ST_IDLE;
            yield_d    = 1'b1;
            ctrl_run_d = '0;
          end else begin
            ctrl_run_d = ctrl_run_q + 1'b1;
          end
        end
      end
      ST_MD_HDR: begin
        if (!bus.TX_Fifo_AFull) begin
          hdr_we     = 1'b1;
          yield_d    = 1'b0;
          word_cnt_d = '0;
          state_d    = ST_MD_DATA;
        end
      end
      ST_MD_DATA: begin
        // Enable is ignored here: a started burst always runs to its full length.
        md_re = !bus.MD_Fifo_Empty && !bus.TX_Fifo_AFull;
        if (md_re) begin
          if (word_cnt_q == CNT_W'(MD_BURST_LEN - 1)) begin
            md_last    = 1'b1;
            word_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      ctrl_run_q <= '0;
      yield_q    <= 1'b0;
      word_cnt_q <= '0;
      seq_q      <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_run_q <= ctrl_run_d;
      yield_q    <= yield_d;
      word_cnt_q <= word_cnt_d;
      seq_q      <= seq_d;
    end
  end

  usb_tx_word_packer #(
    .MD_TAG (MD_TAG)
  ) u_packer (
    .clk      (Clock),
    .rst      (Reset),
    .ctrl_re  (ctrl_re),
    .md_re    (md_re),
    .md_last  (md_last),
    .hdr_we   (hdr_we),
    .hdr_word (hdr_word),
    .ctrl_q   (bus.Control_Fifo_Data),
    .md_q     (bus.MD_Fifo_Data),
    .tx_we    (bus.TX_Fifo_WE),
    .tx_data  (bus.TX_Fifo_Data),
    .last_wr  (last_wr),
    .busy     (pipe_busy)
  );

  assign bus.Control_Fifo_RE = ctrl_re;
  assign bus.MD_Fifo_RE      = md_re;
  assign Busy                = (state_q != ST_IDLE) || pipe_busy;
  assign Burst_Seq           = seq_q;
endmodule

// File: tb/tb_usb_tx_burst_scheduler.sv
// Directed bench for usb_tx_burst_scheduler with MD_BURST_LEN=4, MAX_CTRL_RUN=4.
// FIFO models and the TX write log are advanced by tick(); stimulus changes 2ns after each rising edge.
module tb_usb_tx_burst_scheduler;
  localparam int CNT_W = 12;

  logic        Clock;
  logic        Reset;
  logic        Enable;
  logic        Busy;
  logic [15:0] Burst_Seq;

  usb_tx_burst_scheduler_if #(.CNT_W(CNT_W)) bus ();

  usb_tx_burst_scheduler #(
    .MD_BURST_LEN (4),
    .CNT_W        (CNT_W),
    .MAX_CTRL_RUN (4)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Enable    (Enable),
    .bus       (bus),
    .Busy      (Busy),
    .Burst_Seq (Burst_Seq)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int afull_viol = 0;
  int both_hi = 0;
  bit md_hold = 1'b0;

  logic [39:0] ctrl_fifo[$];
  logic [31:0] md_fifo[$];
  logic [39:0] tx_log[$];
  int          tx_cyc[$];
  int          cre_cyc[$];
  int          mre_cyc[$];

  task automatic update_flags();
    bus.Control_Fifo_Empty = (ctrl_fifo.size() == 0);
    bus.MD_Fifo_Empty      = (md_fifo.size() == 0) || md_hold;
    bus.MD_Fifo_Count      = CNT_W'(md_fifo.size());
  endtask

  task automatic tick();
    bit s_cre, s_mre;
    @(negedge Clock);
    s_cre = bus.Control_Fifo_RE;
    s_mre = bus.MD_Fifo_RE;
    if (bus.TX_Fifo_AFull && (s_cre || s_mre)) afull_viol++;
    if (s_cre && s_mre) both_hi++;
    if (s_cre) cre_cyc.push_back(cyc);
    if (s_mre) mre_cyc.push_back(cyc);
    if (bus.TX_Fifo_WE) begin
      tx_log.push_back(bus.TX_Fifo_Data);
      tx_cyc.push_back(cyc);
    end
    cyc++;
    @(posedge Clock);
    #1;
    if (s_cre && ctrl_fifo.size() > 0) bus.Control_Fifo_Data = ctrl_fifo.pop_front();
    if (s_mre && md_fifo.size() > 0)   bus.MD_Fifo_Data      = md_fifo.pop_front();
    update_flags();
    #1;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    tx_cyc.delete();
    cre_cyc.delete();
    mre_cyc.delete();
    afull_viol = 0;
    both_hi    = 0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (ctrl_fifo.size() == 0 && md_fifo.size() == 0 && !Busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_md_reads(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mre_cyc.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_seq(input string name, input logic [39:0] exp[$]);
    n_cmp++;
    if (tx_log.size() !== exp.size()) begin
      n_err++;
      $display("FAIL %s count: got %0d words, expected %0d", name, tx_log.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (tx_log[i] !== exp[i]) begin
          n_err++;
          $display("FAIL %s word %0d: got %h, expected %h", name, i, tx_log[i], exp[i]);
        end
      end
    end
  endtask

  task automatic check_burst_seq(input string name, input logic [15:0] exp);
    n_cmp++;
    if (Burst_Seq !== exp) begin
      n_err++;
      $display("FAIL %s Burst_Seq: got %0d, expected %0d", name, Burst_Seq, exp);
    end
  endtask

  task automatic check_ok(input string name, input bit ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s: timed out / condition not reached", name);
    end
  endtask

  task automatic test_reset();
    int quiet_bad;
    Reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({bus.Control_Fifo_RE, bus.MD_Fifo_RE, bus.TX_Fifo_WE, bus.TX_Fifo_Data} !== 43'd0) begin
      n_err++;
      $display("FAIL reset outputs: got RE=%b%b WE=%b data=%h, expected all 0",
               bus.Control_Fifo_RE, bus.MD_Fifo_RE, bus.TX_Fifo_WE, bus.TX_Fifo_Data);
    end
    n_cmp++;
    if (Busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset Busy: got %b, expected 0", Busy);
    end
    check_burst_seq("reset", 16'd0);
    Reset = 1'b0;
    clear_logs();
    quiet_bad = 0;
    repeat (20) begin
      tick();
      if (Busy !== 1'b0) quiet_bad++;
    end
    n_cmp++;
    if (tx_log.size() + cre_cyc.size() + mre_cyc.size() + quiet_bad != 0) begin
      n_err++;
      $display("FAIL idle quiet: got %0d WE, %0d RE, %0d busy cycles, expected 0",
               tx_log.size(), cre_cyc.size() + mre_cyc.size(), quiet_bad);
    end
    check_burst_seq("idle", 16'd0);
  endtask

  task automatic test_ctrl();
    logic [39:0] exp[$];
    bit ok;
    clear_logs();
    for (int i = 1; i <= 3; i++) begin
      ctrl_fifo.push_back(40'h01_0000_0000 + 40'(i));
      exp.push_back(40'h01_0000_0000 + 40'(i));
    end
    update_flags();
    wait_done(60, ok);
    check_ok("ctrl done", ok);
    check_seq("ctrl", exp);
    n_cmp++;
    if (cre_cyc.size() !== 3) begin
      n_err++;
      $display("FAIL ctrl RE count: got %0d, expected 3", cre_cyc.size());
    end else if (tx_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (cre_cyc[i] != cre_cyc[0] + i || tx_cyc[i] != cre_cyc[i] + 2) begin
          n_err++;
          $display("FAIL ctrl timing %0d: RE cyc %0d WE cyc %0d, expected RE %0d WE %0d",
                   i, cre_cyc[i], tx_cyc[i], cre_cyc[0] + i, cre_cyc[0] + i + 2);
        end
      end
    end
    check_burst_seq("ctrl", 16'd0);
  endtask

  task automatic test_md_burst();
    logic [39:0] exp[$];
    bit ok;
    clear_logs();
    exp.push_back(40'hD0_0000_0004);
    for (int i = 0; i < 4; i++) begin
      md_fifo.push_back(32'hA + 32'(i));
      exp.push_back({8'hDA, 32'hA + 32'(i)});
    end
    update_flags();
    wait_done(60, ok);
    check_ok("md done", ok);
    check_seq("md", exp);
    n_cmp++;
    if (tx_cyc.size() < 2 || tx_cyc[1] != tx_cyc[0] + 2) begin
      n_err++;
      $display("FAIL md header-to-data gap: got %0d WEs, expected first data WE 2 cycles after header",
               tx_cyc.size());
    end
    check_burst_seq("md", 16'd1);
  endtask

  task automatic test_back_to_back();
    logic [39:0] exp[$];
    bit ok;
    clear_logs();
    for (int i = 0; i < 10; i++) ctrl_fifo.push_back(40'h02_0000_0000 + 40'(i));
    for (int i = 0; i < 8; i++)  md_fifo.push_back(32'h100 + 32'(i));
    update_flags();
    for (int i = 0; i < 4; i++) exp.push_back(40'h02_0000_0000 + 40'(i));
    exp.push_back(40'hD0_0001_0004);
    for (int i = 0; i < 4; i++) exp.push_back({8'hDA, 32'h100 + 32'(i)});
    for (int i = 4; i < 8; i++) exp.push_back(40'h02_0000_0000 + 40'(i));
    exp.push_back(40'hD0_0002_0004);
    for (int i = 4; i < 8; i++) exp.push_back({8'hDA, 32'h100 + 32'(i)});
    for (int i = 8; i < 10; i++) exp.push_back(40'h02_0000_0000 + 40'(i));
    wait_done(300, ok);
    check_ok("arb done", ok);
    check_seq("arb", exp);
    n_cmp++;
    if (both_hi != 0) begin
      n_err++;
      $display("FAIL arb exclusive RE: got %0d cycles with both RE, expected 0", both_hi);
    end
    check_burst_seq("arb", 16'd3);
  endtask

  task automatic test_afull();
    logic [39:0] exp[$];
    bit ok;
    int start, we_in, re_in;
    clear_logs();
    exp.push_back(40'hD0_0003_0004);
    for (int i = 0; i < 4; i++) begin
      md_fifo.push_back(32'h20 + 32'(i));
      exp.push_back({8'hDA, 32'h20 + 32'(i)});
    end
    update_flags();
    wait_md_reads(2, ok);
    check_ok("afull reach 2nd RE", ok);
    bus.TX_Fifo_AFull = 1'b1;
    start = cyc;
    repeat (10) tick();
    bus.TX_Fifo_AFull = 1'b0;
    wait_done(60, ok);
    check_ok("afull done", ok);
    we_in = 0;
    re_in = 0;
    foreach (tx_cyc[i])  if (tx_cyc[i] >= start && tx_cyc[i] < start + 10) we_in++;
    foreach (mre_cyc[i]) if (mre_cyc[i] >= start && mre_cyc[i] < start + 10) re_in++;
    n_cmp++;
    if (we_in > 2 || re_in != 0 || afull_viol != 0) begin
      n_err++;
      $display("FAIL afull hold: got %0d WE, %0d RE, %0d RE-while-AFull, expected <=2, 0, 0",
               we_in, re_in, afull_viol);
    end
    check_seq("afull", exp);
    check_burst_seq("afull", 16'd4);
  endtask

  task automatic test_md_pause();
    logic [39:0] exp[$];
    bit ok;
    int start, re_in;
    clear_logs();
    exp.push_back(40'hD0_0004_0004);
    for (int i = 0; i < 4; i++) begin
      md_fifo.push_back(32'h30 + 32'(i));
      exp.push_back({8'hDA, 32'h30 + 32'(i)});
    end
    update_flags();
    wait_md_reads(2, ok);
    check_ok("pause reach 2nd RE", ok);
    md_hold = 1'b1;
    update_flags();
    start = cyc;
    repeat (5) tick();
    n_cmp++;
    if (Busy !== 1'b1) begin
      n_err++;
      $display("FAIL pause busy: got %b, expected 1 while burst is paused", Busy);
    end
    md_hold = 1'b0;
    update_flags();
    re_in = 0;
    foreach (mre_cyc[i]) if (mre_cyc[i] >= start) re_in++;
    n_cmp++;
    if (re_in != 0) begin
      n_err++;
      $display("FAIL pause RE: got %0d reads while empty, expected 0", re_in);
    end
    wait_done(60, ok);
    check_ok("pause done", ok);
    check_seq("pause", exp);
    check_burst_seq("pause", 16'd5);
  endtask

  task automatic test_reset_mid_burst();
    logic [39:0] exp[$];
    bit ok;
    clear_logs();
    for (int i = 0; i < 4; i++) md_fifo.push_back(32'h40 + 32'(i));
    update_flags();
    wait_md_reads(2, ok);
    check_ok("rst reach 2nd RE", ok);
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.Control_Fifo_RE, bus.MD_Fifo_RE, bus.TX_Fifo_WE, bus.TX_Fifo_Data, Busy} !== 44'd0) begin
      n_err++;
      $display("FAIL mid-burst reset outputs: got RE=%b%b WE=%b data=%h busy=%b, expected all 0",
               bus.Control_Fifo_RE, bus.MD_Fifo_RE, bus.TX_Fifo_WE, bus.TX_Fifo_Data, Busy);
    end
    check_burst_seq("mid-burst reset", 16'd0);
    repeat (2) tick();
    md_fifo.delete();
    update_flags();
    Reset = 1'b0;
    clear_logs();
    exp.push_back(40'hD0_0000_0004);
    for (int i = 0; i < 4; i++) begin
      md_fifo.push_back(32'h50 + 32'(i));
      exp.push_back({8'hDA, 32'h50 + 32'(i)});
    end
    update_flags();
    wait_done(60, ok);
    check_ok("restart done", ok);
    check_seq("restart", exp);
    check_burst_seq("restart", 16'd1);
  endtask

  initial begin
    Reset                 = 1'b1;
    Enable                = 1'b1;
    bus.Control_Fifo_Data = '0;
    bus.MD_Fifo_Data      = '0;
    bus.TX_Fifo_AFull     = 1'b0;
    update_flags();
    test_reset();
    test_ctrl();
    test_md_burst();
    test_back_to_back();
    test_afull();
    test_md_pause();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
